// File: rtl/osc_note_sequencer.sv
// Note-table sequencer for an audio oscillator: plays host-written notes back to back,
// advancing only on oscillator sample boundaries.
module osc_note_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DUR_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_divisor,
    input  logic [7:0]        i_wr_duty,
    input  logic              i_wr_waveform,
    input  logic [DUR_W-1:0]  i_wr_duration,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic [ADDR_W-1:0] i_last_index,
    input  logic              i_sample_strobe,
    output logic [31:0]       o_divisor,
    output logic [7:0]        o_duty,
    output logic              o_waveform,
    output logic              o_gate,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_note_index,
    output logic              o_note_start,
    output logic              o_done
);

    localparam int unsigned EntryW = DUR_W + 41;

    typedef enum logic [2:0] {StIdle, StFetch, StArm, StFetchNext, StPlay} state_e;

    state_e            r_state, w_state_next;
    logic [EntryW-1:0] r_mem [DEPTH];
    logic [EntryW-1:0] r_rd_data;
    logic [EntryW-1:0] r_pending;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [ADDR_W-1:0] r_pend_idx;
    logic [DUR_W-1:0]  r_remaining;
    logic              r_eos;

    logic [31:0]       w_pend_div;
    logic [7:0]        w_pend_duty;
    logic              w_pend_wave;
    logic [DUR_W-1:0]  w_pend_dur;
    logic [DUR_W-1:0]  w_dur_eff;
    logic [ADDR_W-1:0] w_next_idx;
    logic              w_next_eos;
    logic              w_start_ok, w_apply, w_finish, w_decr, w_stop_now;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_pend_div  = r_pending[DUR_W+40:DUR_W+9];
    assign w_pend_duty = r_pending[DUR_W+8:DUR_W+1];
    assign w_pend_wave = r_pending[DUR_W];
    assign w_pend_dur  = r_pending[DUR_W-1:0];
    assign w_dur_eff   = (w_pend_dur == '0) ? DUR_W'(1) : w_pend_dur;

    // Table read data is old-on-collision; pending is a private copy, so later writes
    // never disturb a note already fetched.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= {i_wr_divisor, i_wr_duty, i_wr_waveform, i_wr_duration};
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_comb begin
        if (r_pend_idx == i_last_index) begin
            w_next_idx = '0;
            w_next_eos = !i_loop_en;
        end else begin
            w_next_idx = r_pend_idx + ADDR_W'(1);
            w_next_eos = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_apply      = 1'b0;
        w_finish     = 1'b0;
        w_decr       = 1'b0;
        w_stop_now   = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        unique case (r_state)
            StIdle: begin
                // A start coinciding with the done pulse is dropped.
                if (i_start && !i_stop && !o_done) begin
                    w_start_ok   = 1'b1;
                    w_rd_en      = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StFetch: w_state_next = StArm;
            StArm: begin
                if (i_sample_strobe) begin
                    w_apply      = 1'b1;
                    w_rd_en      = 1'b1;
                    w_rd_addr    = w_next_idx;
                    w_state_next = StFetchNext;
                end
            end
            StFetchNext: begin
                w_decr       = i_sample_strobe && (r_remaining > DUR_W'(1));
                w_state_next = StPlay;
            end
            StPlay: begin
                if (i_sample_strobe) begin
                    if (r_remaining > DUR_W'(1)) begin
                        w_decr = 1'b1;
                    end else if (r_eos) begin
                        w_finish     = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_apply      = 1'b1;
                        w_rd_en      = 1'b1;
                        w_rd_addr    = w_next_idx;
                        w_state_next = StFetchNext;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (r_state != StIdle && i_stop) begin
            w_apply      = 1'b0;
            w_finish     = 1'b0;
            w_decr       = 1'b0;
            w_rd_en      = 1'b0;
            w_stop_now   = 1'b1;
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_divisor    <= '0;
            o_duty       <= '0;
            o_waveform   <= 1'b0;
            o_gate       <= 1'b0;
            o_busy       <= 1'b0;
            o_note_index <= '0;
            o_note_start <= 1'b0;
            o_done       <= 1'b0;
            r_pending    <= '0;
            r_rd_idx     <= '0;
            r_pend_idx   <= '0;
            r_remaining  <= '0;
            r_eos        <= 1'b0;
        end else begin
            o_note_start <= 1'b0;
            o_done       <= 1'b0;
            if (w_start_ok) begin
                o_busy <= 1'b1;
            end
            if (w_rd_en) begin
                r_rd_idx <= w_rd_addr;
            end
            if (r_state == StFetch || r_state == StFetchNext) begin
                r_pending  <= r_rd_data;
                r_pend_idx <= r_rd_idx;
            end
            if (w_apply) begin
                o_divisor    <= w_pend_div;
                o_duty       <= w_pend_duty;
                o_waveform   <= w_pend_wave;
                o_gate       <= 1'b1;
                o_note_index <= r_pend_idx;
                o_note_start <= 1'b1;
                r_remaining  <= w_dur_eff;
                r_eos        <= w_next_eos;
            end
            if (w_decr) begin
                r_remaining <= r_remaining - DUR_W'(1);
            end
            if (w_finish || w_stop_now) begin
                o_gate      <= 1'b0;
                o_busy      <= 1'b0;
                r_remaining <= '0;
            end
            if (w_finish) begin
                o_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_osc_note_sequencer.sv
// Directed bench for osc_note_sequencer: one task per scenario, hand-computed expectations.
module tb_osc_note_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_divisor = '0;
    logic [7:0]  wr_duty = '0;
    logic        wr_waveform = 1'b0;
    logic [15:0] wr_duration = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  last_index = '0;
    logic        sample_strobe = 1'b0;
    logic [31:0] divisor;
    logic [7:0]  duty;
    logic        waveform;
    logic        gate;
    logic        busy;
    logic [3:0]  note_index;
    logic        note_start;
    logic        done;

    int checks = 0;
    int failures = 0;

    int          seq_idx  [7]  = '{0, 0, 0, 1, 2, 2, 2};
    bit          seq_ns   [7]  = '{1, 0, 0, 1, 1, 0, 0};
    logic [31:0] seq_div  [7]  = '{32'h111, 32'h111, 32'h111, 32'h222, 32'h333, 32'h333,
                                   32'h333};
    int          loop_idx [14] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 2, 0, 0};
    bit          loop_ns  [14] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0};

    always #5 clk = ~clk;

    osc_note_sequencer #(
        .DEPTH (16),
        .ADDR_W(4),
        .DUR_W (16)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_divisor   (wr_divisor),
        .i_wr_duty      (wr_duty),
        .i_wr_waveform  (wr_waveform),
        .i_wr_duration  (wr_duration),
        .i_start        (start),
        .i_stop         (stop),
        .i_loop_en      (loop_en),
        .i_last_index   (last_index),
        .i_sample_strobe(sample_strobe),
        .o_divisor      (divisor),
        .o_duty         (duty),
        .o_waveform     (waveform),
        .o_gate         (gate),
        .o_busy         (busy),
        .o_note_index   (note_index),
        .o_note_start   (note_start),
        .o_done         (done)
    );

    task automatic write_entry(input logic [3:0] a, input logic [31:0] dv, input logic [7:0] dt,
                               input logic wf, input logic [15:0] dur);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_divisor = dv; wr_duty = dt; wr_waveform = wf;
        wr_duration = dur;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Strobes 5 clk apart; returns on the negedge just after the strobe edge.
    task automatic do_strobe();
        repeat (4) @(negedge clk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({divisor, duty, waveform, gate, busy, note_index, note_start, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got div=%h duty=%h gate=%b busy=%b idx=%0d exp all 0",
                     divisor, duty, gate, busy, note_index);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({gate, busy, note_start, done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release got gate=%b busy=%b ns=%b done=%b exp 0",
                     gate, busy, note_start, done);
        end
    endtask

    task automatic test_single_note();
        write_entry(4'd0, 32'h0100_0000, 8'd64, 1'b1, 16'd4);
        last_index = 4'd0;
        loop_en = 1'b0;
        do_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy got %b exp 1", busy);
        end
        do_strobe();
        checks++;
        if ({note_start, gate, divisor, duty, waveform, note_index} !==
            {1'b1, 1'b1, 32'h0100_0000, 8'd64, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL single_apply got ns=%b gate=%b div=%h duty=%0d wf=%b idx=%0d",
                     note_start, gate, divisor, duty, waveform, note_index);
        end
        for (int s = 2; s <= 4; s++) begin
            do_strobe();
            checks++;
            if ({note_start, gate, done} !== 3'b010) begin
                failures++;
                $display("FAIL single_mid%0d got ns=%b gate=%b done=%b exp 0 1 0",
                         s, note_start, gate, done);
            end
        end
        repeat (4) @(negedge clk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        start = 1'b1;
        checks++;
        if ({done, gate, busy, divisor} !== {1'b1, 1'b0, 1'b0, 32'h0100_0000}) begin
            failures++;
            $display("FAIL single_done got done=%b gate=%b busy=%b div=%h exp 1 0 0 01000000",
                     done, gate, busy, divisor);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_start_on_done got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic load_three();
        write_entry(4'd0, 32'h111, 8'd10, 1'b0, 16'd3);
        write_entry(4'd1, 32'h222, 8'd20, 1'b1, 16'd1);
        write_entry(4'd2, 32'h333, 8'd30, 1'b0, 16'd2);
        last_index = 4'd2;
    endtask

    task automatic test_sequence();
        load_three();
        loop_en = 1'b0;
        do_start();
        for (int s = 0; s < 7; s++) begin
            do_strobe();
            checks++;
            if ({note_start, note_index, divisor, done, gate} !==
                {seq_ns[s], 4'(seq_idx[s]), seq_div[s], s == 6, s != 6}) begin
                failures++;
                $display("FAIL seq_strobe%0d got ns=%b idx=%0d div=%h done=%b gate=%b",
                         s + 1, note_start, note_index, divisor, done, gate);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL seq_busy_end got %b exp 0", busy);
        end
    endtask

    task automatic test_loop();
        loop_en = 1'b1;
        do_start();
        for (int s = 0; s < 14; s++) begin
            do_strobe();
            checks++;
            if ({note_start, note_index, done, gate} !==
                {loop_ns[s], 4'(loop_idx[s]), 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL loop_strobe%0d got ns=%b idx=%0d done=%b gate=%b",
                         s + 1, note_start, note_index, done, gate);
            end
        end
        do_stop();
        checks++;
        if ({gate, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL loop_stop got gate=%b busy=%b done=%b exp 0", gate, busy, done);
        end
        loop_en = 1'b1;
        do_start();
        for (int s = 0; s < 13; s++) begin
            if (s == 10) loop_en = 1'b0;
            do_strobe();
            checks++;
            if ({note_start, note_index, done} !==
                {(s != 12) && loop_ns[s], 4'((s == 12) ? 2 : loop_idx[s]), s == 12}) begin
                failures++;
                $display("FAIL loopclr_strobe%0d got ns=%b idx=%0d done=%b",
                         s + 1, note_start, note_index, done);
            end
        end
    endtask

    task automatic test_dur_zero();
        write_entry(4'd0, 32'hA, 8'd1, 1'b1, 16'd0);
        write_entry(4'd1, 32'hB, 8'd2, 1'b0, 16'd2);
        last_index = 4'd1;
        loop_en = 1'b0;
        do_start();
        do_strobe();
        checks++;
        if ({note_start, divisor} !== {1'b1, 32'hA}) begin
            failures++;
            $display("FAIL dur0_first got ns=%b div=%h exp 1 0000000a", note_start, divisor);
        end
        do_strobe();
        checks++;
        if ({note_start, divisor, note_index} !== {1'b1, 32'hB, 4'd1}) begin
            failures++;
            $display("FAIL dur0_next got ns=%b div=%h idx=%0d exp 1 0000000b 1",
                     note_start, divisor, note_index);
        end
        do_strobe();
        do_strobe();
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL dur0_done got done=%b busy=%b exp 1 0", done, busy);
        end
    endtask

    task automatic test_stop_start();
        write_entry(4'd0, 32'hC, 8'd3, 1'b1, 16'd2);
        write_entry(4'd1, 32'hD, 8'd4, 1'b0, 16'd1);
        last_index = 4'd1;
        loop_en = 1'b0;
        do_start();
        do_strobe();
        do_start();
        checks++;
        if ({busy, note_index, divisor, note_start} !== {1'b1, 4'd0, 32'hC, 1'b0}) begin
            failures++;
            $display("FAIL start_while_busy got busy=%b idx=%0d div=%h ns=%b",
                     busy, note_index, divisor, note_start);
        end
        do_strobe();
        repeat (4) @(negedge clk);
        sample_strobe = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        stop = 1'b0;
        checks++;
        if ({note_start, done, gate, busy, divisor} !== {4'b0000, 32'hC}) begin
            failures++;
            $display("FAIL stop_terminal got ns=%b done=%b gate=%b busy=%b div=%h",
                     note_start, done, gate, busy, divisor);
        end
        do_strobe();
        checks++;
        if ({note_start, gate, busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_strobe got ns=%b gate=%b busy=%b exp 0", note_start, gate, busy);
        end
    endtask

    task automatic test_reset_live();
        write_entry(4'd0, 32'h100, 8'd5, 1'b1, 16'd3);
        write_entry(4'd1, 32'h200, 8'd6, 1'b0, 16'd2);
        last_index = 4'd1;
        loop_en = 1'b1;
        do_start();
        do_strobe();
        write_entry(4'd0, 32'h999, 8'd7, 1'b0, 16'd3);
        checks++;
        if ({divisor, duty, waveform} !== {32'h100, 8'd5, 1'b1}) begin
            failures++;
            $display("FAIL live_write_hold got div=%h duty=%0d wf=%b exp 100 5 1",
                     divisor, duty, waveform);
        end
        do_strobe();
        do_strobe();
        do_strobe();
        checks++;
        if ({divisor, note_index} !== {32'h200, 4'd1}) begin
            failures++;
            $display("FAIL live_second got div=%h idx=%0d exp 200 1", divisor, note_index);
        end
        do_strobe();
        do_strobe();
        checks++;
        if ({note_start, divisor, duty, note_index} !== {1'b1, 32'h999, 8'd7, 4'd0}) begin
            failures++;
            $display("FAIL live_next_pass got ns=%b div=%h duty=%0d idx=%0d exp 1 999 7 0",
                     note_start, divisor, duty, note_index);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({divisor, duty, waveform, gate, busy, note_index, note_start, done} !== '0) begin
            failures++;
            $display("FAIL async_reset got div=%h gate=%b busy=%b idx=%0d exp all 0",
                     divisor, gate, busy, note_index);
        end
        @(negedge clk);
        reset = 1'b0;
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_sequence();
        test_loop();
        test_dur_zero();
        test_stop_start();
        test_reset_live();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osc_note_sequencer.md
Name: osc_note_sequencer

Overview:
- Sequences an `audio_oscillator` through a programmable list of notes. Drives its `divisor`, `duty` and `waveform` inputs, plus a `gate` for the downstream mute.
- Holds a small note table written by the host. Each note lasts a set number of oscillator samples.
- Counts samples on `sample_strobe`, which is wired to the oscillator's `tvalid & tready`.
- Changes oscillator settings only at sample boundaries, with no gap between notes.

Parameters:
- DEPTH, 16, number of note-table entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- DUR_W, 16, width of the note duration field, in samples.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write note-table entry `wr_addr`
- wr_addr  in  ADDR_W  table write address
- wr_divisor  in  32  phase increment for the entry
- wr_duty  in  8  duty value for the entry
- wr_waveform  in  1  waveform select for the entry (1 = square, 0 = saw)
- wr_duration  in  DUR_W  note length in samples; 0 is treated as 1
- start  in  1  begin playback at index 0
- stop  in  1  abort playback
- loop_en  in  1  restart at index 0 after `last_index`
- last_index  in  ADDR_W  final table entry of the sequence
- sample_strobe  in  1  one pulse per oscillator sample transaction
- divisor  out  32  to the oscillator
- duty  out  8  to the oscillator
- waveform  out  1  to the oscillator
- gate  out  1  1 while a note sounds
- busy  out  1  1 when not IDLE
- note_index  out  ADDR_W  index of the sounding note
- note_start  out  1  one-cycle pulse when a note is applied
- done  out  1  one-cycle pulse on natural end of the sequence

Behaviour:
- Reset values: all outputs 0, state IDLE, `remaining` 0. The note table is not reset.
- The table has one synchronous write port and one synchronous read port with 1-cycle read latency.
  - Writes are accepted in any state.
  - A write to an entry already fetched does not affect the current pending or playing note.
- States: IDLE, FETCH, ARM, FETCH_NEXT, PLAY.
- IDLE:
  - `start=1` and `stop=0`: read address 0, go to FETCH, assert `busy`.
  - `start` while busy is ignored.
- FETCH: `pending <= table[rd_addr]`, then go to ARM.
- ARM: wait for `sample_strobe`. On the strobe, in the same edge:
  - `divisor`, `duty`, `waveform <= pending`;
  - `gate <= 1`;
  - `note_index <= rd_addr`;
  - `remaining <= max(duration, 1)`;
  - `note_start` pulses;
  - compute `next_idx`, issue the read, go to FETCH_NEXT.
- `next_idx`:
  - if `note_index == last_index`: 0 when `loop_en=1`, otherwise end-of-sequence flag set;
  - else `note_index + 1`, wrapping at DEPTH.
- FETCH_NEXT: `pending <= table[next_idx]`, then go to PLAY.
- Strobe counting: in ARM-completed, FETCH_NEXT and PLAY, each `sample_strobe` with `remaining > 1` decrements `remaining`.
- Terminal strobe (`remaining == 1`) in PLAY:
  - End-of-sequence flag set: `gate <= 0`, `busy <= 0`, `done` pulses, go to IDLE. `divisor`, `duty`, `waveform` and `note_index` hold.
  - Otherwise: apply `pending` exactly as in ARM on this same edge, so the note boundary is seamless. Then go to FETCH_NEXT.
- Precondition: `sample_strobe` pulses are at least 3 clk apart. The bench must respect this; behaviour is unspecified otherwise.
- `loop_en` and `last_index` are sampled when `next_idx` is computed (at note application).
- `stop`:
  - in any non-IDLE state: next state IDLE, `gate <= 0`, `busy <= 0`, no `done`, `remaining <= 0`; `divisor`, `duty`, `waveform` hold;
  - has priority over `start` and over a simultaneous terminal strobe (no `note_start` or `done` that cycle).
- `start` asserted in the same cycle as the `done` pulse is ignored. It must be re-asserted once IDLE.
- Asynchronous `reset` mid-playback returns to reset values immediately.

Test Plan:
- Single note: write entry 0 = {divisor 0x0100_0000, duty 64, square, duration 4}, `last_index` 0, `loop_en` 0, start, strobe every 5 clk -> outputs applied on the 1st strobe with `note_start`; `gate` falls and `done` pulses on the 5th strobe; `busy` 0 after.
- Seamless sequence: entries 0..2 with durations 3, 1, 2, `last_index` 2 -> `note_start` on strobes 1, 4, 5; `note_index` 0, 1, 2; `done` on strobe 7; outputs never show a stale entry between notes.
- Loop: same table, `loop_en=1`, 14 strobes -> `note_index` returns to 0 on strobe 7 and 13, no `done`; clearing `loop_en` before strobe 11 -> `done` on strobe 13.
- Duration 0: entry with duration 0 -> behaves as duration 1 (next `note_start` on the following strobe).
- Stop and start collisions: stop coincident with a terminal strobe -> no `note_start`, no `done`, `gate` 0, IDLE; start while busy has no effect.
- Reset and live writes: async reset asserted mid-note -> all outputs 0 immediately; rewriting the currently playing entry during PLAY leaves the current outputs unchanged and takes effect on the next loop pass.
